// File: rtl/ota_cmd_ctrl.sv
// SPI command-frame sequencer: parses SYNC/OP/ARG/CHK frames, drives the status LEDs
// and commits a one-shot reboot request with an image slot, then locks until reset.
module ota_cmd_ctrl #(
   parameter int unsigned TIMEOUT_CYC  = 250000,
   parameter int unsigned REBOOT_DELAY = 1000,
   parameter logic [7:0]  PERIOD_RST   = 8'd121
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       spi_cs,
   output logic       led_verde,
   output logic       led_verm,
   output logic [1:0] boot_sel,
   output logic       boot_req,
   output logic       cmd_ok,
   output logic [7:0] err_count
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned DW = $clog2(REBOOT_DELAY + 1);
   localparam logic [7:0] Sync = 8'hA5;

   typedef enum logic [2:0] {
      StIdle, StGetOp, StGetArg, StGetChk, StExec, StRebootWait, StLocked
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  op_q, op_d, arg_q, arg_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [DW-1:0] wait_q, wait_d;
   logic [1:0]  mode_q, mode_d;
   logic [7:0]  period_q, period_d;
   logic [23:0] blink_q, blink_d;
   logic        phase_q, phase_d;
   logic [1:0]  sel_q, sel_d;
   logic        ok_q, ok_d;
   logic [7:0]  err_q;
   logic        err_inc;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      arg_d    = arg_q;
      tmo_d    = tmo_q;
      wait_d   = wait_q;
      mode_d   = mode_q;
      period_d = period_q;
      sel_d    = sel_q;
      ok_d     = 1'b0;
      err_inc  = 1'b0;
      phase_d  = phase_q;
      if (blink_q == {period_q, 16'hFFFF}) begin
         blink_d = '0;
         phase_d = ~phase_q;
      end else begin
         blink_d = blink_q + 24'd1;
      end

      unique case (state_q)
         StIdle: begin
            tmo_d = '0;
            if (rx_valid && !spi_cs && rx_data == Sync) state_d = StGetOp;
         end
         StGetOp, StGetArg, StGetChk: begin
            // cs deassertion wins over a byte arriving in the same cycle
            if (spi_cs) begin
               state_d = StIdle;
               err_inc = 1'b1;
            end else if (rx_valid) begin
               tmo_d = '0;
               if (state_q == StGetOp) begin
                  op_d    = rx_data;
                  state_d = StGetArg;
               end else if (state_q == StGetArg) begin
                  arg_d   = rx_data;
                  state_d = StGetChk;
               end else if (rx_data == (Sync ^ op_q ^ arg_q)) begin
                  state_d = StExec;
               end else begin
                  state_d = StIdle;
                  err_inc = 1'b1;
               end
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               state_d = StIdle;
               err_inc = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         StExec: begin
            state_d = StIdle;
            case (op_q)
               8'h01: begin
                  if (arg_q > 8'd3) begin
                     err_inc = 1'b1;
                  end else begin
                     mode_d  = arg_q[1:0];
                     blink_d = '0;
                     phase_d = 1'b0;
                     ok_d    = 1'b1;
                  end
               end
               8'h02: begin
                  period_d = arg_q;
                  blink_d  = '0;
                  phase_d  = 1'b0;
                  ok_d     = 1'b1;
               end
               8'h03: begin
                  if (arg_q > 8'd3) begin
                     err_inc = 1'b1;
                  end else begin
                     sel_d   = arg_q[1:0];
                     wait_d  = '0;
                     state_d = StRebootWait;
                     ok_d    = 1'b1;
                  end
               end
               8'h04:   ok_d    = 1'b1;
               default: err_inc = 1'b1;
            endcase
         end
         StRebootWait: begin
            if (wait_q == DW'(REBOOT_DELAY - 1)) state_d = StLocked;
            else                                  wait_d  = wait_q + DW'(1);
         end
         StLocked: state_d = StLocked;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         op_q     <= '0;
         arg_q    <= '0;
         tmo_q    <= '0;
         wait_q   <= '0;
         mode_q   <= 2'd1;
         period_q <= PERIOD_RST;
         blink_q  <= '0;
         phase_q  <= 1'b0;
         sel_q    <= '0;
         ok_q     <= 1'b0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         arg_q    <= arg_d;
         tmo_q    <= tmo_d;
         wait_q   <= wait_d;
         mode_q   <= mode_d;
         period_q <= period_d;
         blink_q  <= blink_d;
         phase_q  <= phase_d;
         sel_q    <= sel_d;
         ok_q     <= ok_d;
         if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
      end
   end

   always_comb begin
      led_verde = 1'b0;
      led_verm  = 1'b0;
      if (state_q == StLocked) begin
         led_verde = 1'b1;
         led_verm  = 1'b1;
      end else begin
         unique case (mode_q)
            2'd0: begin led_verde = 1'b0;    led_verm = 1'b0;     end
            2'd1: begin led_verde = phase_q; led_verm = phase_q;  end
            2'd2: begin led_verde = phase_q; led_verm = ~phase_q; end
            2'd3: begin led_verde = 1'b1;    led_verm = 1'b1;     end
            default: ;
         endcase
      end
   end

   assign boot_req  = (state_q == StLocked);
   assign boot_sel  = sel_q;
   assign cmd_ok    = ok_q;
   assign err_count = err_q;

endmodule

// File: doc/ota_cmd_ctrl.md
Name: ota_cmd_ctrl

Overview:
Command sequencer behind the SPI slave in the bootloader/menu image. It parses 4-byte command frames from the RP2040, which arrive as rx_data/rx_valid byte strobes framed by spi_cs. It drives the two status LEDs (mode and blink period) and commits a reboot request with a selected image slot to the configuration/warm-boot logic. Once a reboot is committed, the block is locked until reset.

Parameters:
TIMEOUT_CYC, 250000, maximum clk cycles between bytes inside a frame before abort (10 ms at 25 MHz)
REBOOT_DELAY, 1000, clk cycles between a valid REBOOT command and assertion of boot_req
PERIOD_RST, 121, reset value of the period argument register (half-period = (arg+1)*65536 cycles)

Ports:
clk  in  1  system clock, 25 MHz
rst  in  1  asynchronous reset, active-high
rx_data  in  8  byte from the SPI slave; valid when rx_valid=1
rx_valid  in  1  one-cycle strobe, one per received byte
spi_cs  in  1  SPI chip select, active-low; high = no transaction
led_verde  out  1  green LED
led_verm  out  1  red LED
boot_sel  out  2  image slot for reboot; stable while boot_req=1
boot_req  out  1  sticky reboot request to warm-boot logic
cmd_ok  out  1  one-cycle pulse per executed valid frame
err_count  out  8  saturating count of rejected frames

Behaviour:
- Reset values: led_verde=0, led_verm=0, boot_sel=0, boot_req=0, cmd_ok=0, err_count=0, led mode=1, period arg=PERIOD_RST, state=IDLE, blink counter=0, phase=0.
- Frame format: SYNC(0xA5), OP, ARG, CHK, where CHK = 0xA5 ^ OP ^ ARG.
- FSM states: IDLE, GET_OP, GET_ARG, GET_CHK, EXEC, REBOOT_WAIT, LOCKED.
- IDLE: on rx_valid with cs low, byte 0xA5 → GET_OP. Any other byte is discarded silently, with no error.
- GET_OP / GET_ARG / GET_CHK: each rx_valid latches the byte and advances the state. A checksum mismatch in GET_CHK → err_count+1, back to IDLE. A match → EXEC.
- Abort from GET_*: spi_cs high for any cycle, or TIMEOUT_CYC cycles with no rx_valid. Either → IDLE, err_count+1. The timeout counter clears on every rx_valid.
- EXEC lasts exactly one cycle:
  - OP 0x01 LED_MODE: mode = ARG[1:0]. ARG>3 is an error.
  - OP 0x02 SET_PERIOD: period arg = ARG (any value is legal).
  - OP 0x03 REBOOT: boot_sel = ARG[1:0] → REBOOT_WAIT. ARG>3 is an error.
  - OP 0x04 PING: no effect.
  - Any other OP: error.
  - cmd_ok=1 in the cycle after EXEC for valid ops only. Errors increment err_count instead.
  - The next state is IDLE unless the op is REBOOT. A byte arriving during EXEC is dropped.
- Latency: CHK strobe at cycle N → EXEC at N+1 → effect and cmd_ok visible at N+2.
- REBOOT_WAIT: counts REBOOT_DELAY cycles, ignoring all bytes, then → LOCKED.
- LOCKED: boot_req=1 held, boot_sel frozen, all bytes ignored, LEDs both on. Only rst exits.
- err_count saturates at 255.
- LED modes:
  - 0: both off.
  - 1: both toggle in phase (menu blink).
  - 2: alternate (verde=phase, verm=~phase).
  - 3: both on.
- Blink counter: counts to (arg+1)*65536-1, then wraps to 0 and toggles phase. This uses a 24-bit counter; the compare is on {arg,16'hFFFF}.
- A valid LED_MODE or SET_PERIOD clears the counter and phase to 0 in the EXEC cycle.
- rst asserted mid-frame or mid-REBOOT_WAIT returns every register to its reset value immediately; boot_req drops asynchronously.

Test Plan:
- Reset, no traffic → both LEDs toggle together every 122*65536=7,995,392 cycles; boot_req=0, err_count=0.
- Frame A5 01 02 A6 → cmd_ok pulse 2 cycles after the CHK strobe; LEDs alternate, with verde=0 and verm=1 immediately after.
- Frame A5 02 00 A7 followed by A5 01 01 A5 → in-phase blink with a half-period of 65536 cycles, measured exactly.
- Bad checksum A5 01 02 00 → err_count=1, no cmd_ok, LED mode unchanged. Stray bytes 00 FF before A5 → no error.
- Abort cases: A5 01, then spi_cs high → IDLE, err_count=1. Repeat with cs held low and 250000 idle cycles → err_count=2. A following valid frame executes.
- Frame A5 03 02 A4 → boot_sel=2 at EXEC, boot_req=1 exactly REBOOT_DELAY cycles later and held. A later A5 01 00 A4 is ignored. rst → boot_req=0 immediately.
